// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the dual-issue register file and its
// pending-writer scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREGS);
  localparam int unsigned CNT_W     = 2;
  // Projected counter values carry two extra bits: one for headroom, one for sign.
  localparam int unsigned SUM_W     = CNT_W + 2;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef logic [SUM_W-1:0] cnt_sum_t;

  // Projected count is negative.
  function automatic logic cnt_under(cnt_sum_t v);
    return v[SUM_W-1];
  endfunction

  // Projected count is non-negative but does not fit in CNT_W bits.
  function automatic logic cnt_over(cnt_sum_t v);
    return !v[SUM_W-1] && (|v[SUM_W-2:CNT_W]);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-writer counter for one architectural register. Saturates at both
// ends and reports the clamp as a one-cycle ovf/unf flag.
module regfile_scoreboard_sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cnt_sum_t         sum;

  // Next count: cnt + inc - dec, clamped into [0, 2^CNT_W-1].
  always_comb begin
    sum   = {2'b00, cnt_q} + {{CNT_W{1'b0}}, inc} - {{CNT_W{1'b0}}, dec};
    unf   = cnt_under(sum);
    ovf   = cnt_over(sum);
    cnt_d = sum[CNT_W-1:0];
    if (unf) begin
      cnt_d = '0;
    end else if (ovf) begin
      cnt_d = '1;
    end
  end

  // Counter state; reset discards every outstanding reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry, 2-write / 4-read register file with write-through bypass and a
// per-register pending-writer scoreboard that drives RAW busy and WAW full flags.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_en0,
  input  logic [REG_IDX_W-1:0] wb_rd0,
  input  logic [XLEN-1:0]      wb_data0,
  input  logic                 wb_en1,
  input  logic [REG_IDX_W-1:0] wb_rd1,
  input  logic [XLEN-1:0]      wb_data1,
  input  logic                 iss_en0,
  input  logic [REG_IDX_W-1:0] iss_rd0,
  input  logic                 iss_en1,
  input  logic [REG_IDX_W-1:0] iss_rd1,
  input  logic [REG_IDX_W-1:0] rs1_0,
  input  logic [REG_IDX_W-1:0] rs2_0,
  input  logic [REG_IDX_W-1:0] rs1_1,
  input  logic [REG_IDX_W-1:0] rs2_1,
  output logic [XLEN-1:0]      rdata1_0,
  output logic [XLEN-1:0]      rdata2_0,
  output logic [XLEN-1:0]      rdata1_1,
  output logic [XLEN-1:0]      rdata2_1,
  output logic                 busy1_0,
  output logic                 busy2_0,
  output logic                 busy1_1,
  output logic                 busy2_1,
  output logic                 dst_full0,
  output logic                 dst_full1,
  output logic                 sb_err
);

  logic [XLEN-1:0]                 mem_q [NREGS];
  logic [NREGS-1:1][1:0]           inc;
  logic [NREGS-1:0][1:0]           dec;
  logic [NREGS-1:0][CNT_W-1:0]     cnt;
  logic [NREGS-1:0]                ovf, unf;
  logic                            sb_err_q;
  logic [3:0][REG_IDX_W-1:0]       rs;
  logic [3:0][XLEN-1:0]            rdata;
  logic [3:0]                      busy;
  cnt_sum_t                        proj0, proj1;

  // Data array; x0 is never written so it stays 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wb_en0 && wb_rd0 != ZERO_REG) mem_q[wb_rd0] <= wb_data0;
      // Slot 1 is younger in program order, so it overrides slot 0.
      if (wb_en1 && wb_rd1 != ZERO_REG) mem_q[wb_rd1] <= wb_data1;
    end
  end

  // Per-register reservation (inc) and retirement (dec) counts this cycle.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      inc[r] = {1'b0, iss_en0 && iss_rd0 == REG_IDX_W'(r)}
             + {1'b0, iss_en1 && iss_rd1 == REG_IDX_W'(r)};
      dec[r] = {1'b0, wb_en0 && wb_rd0 == REG_IDX_W'(r)}
             + {1'b0, wb_en1 && wb_rd1 == REG_IDX_W'(r)};
    end
  end

  assign cnt[0] = '0;
  assign ovf[0] = 1'b0;
  assign unf[0] = 1'b0;

  for (genvar r = 1; r < int'(NREGS); r++) begin : g_cnt
    regfile_scoreboard_sb_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .cnt   (cnt[r]),
      .ovf   (ovf[r]),
      .unf   (unf[r])
    );
  end

  assign rs = {rs2_1, rs1_1, rs2_0, rs1_0};

  // Read ports: x0, then slot 1 bypass, then slot 0 bypass, then the array.
  // Busy ignores same-cycle issue but honours same-cycle retirement.
  always_comb begin
    rdata = '0;
    busy  = '0;
    for (int p = 0; p < 4; p++) begin
      rdata[p] = mem_q[rs[p]];
      if (wb_en0 && wb_rd0 == rs[p]) rdata[p] = wb_data0;
      if (wb_en1 && wb_rd1 == rs[p]) rdata[p] = wb_data1;
      busy[p] = {2'b00, cnt[rs[p]]} > {{CNT_W{1'b0}}, dec[rs[p]]};
      if (rs[p] == ZERO_REG) begin
        rdata[p] = '0;
        busy[p]  = 1'b0;
      end
    end
  end

  assign {rdata2_1, rdata1_1, rdata2_0, rdata1_0} = rdata;
  assign {busy2_1, busy1_1, busy2_0, busy1_0}     = busy;

  // Would one more reservation overflow? Slot 1 also sees slot 0's same-rd claim.
  always_comb begin
    proj0 = {2'b00, cnt[iss_rd0]} + SUM_W'(1) - {{CNT_W{1'b0}}, dec[iss_rd0]};
    proj1 = {2'b00, cnt[iss_rd1]} + SUM_W'(1) + SUM_W'(iss_en0 && iss_rd0 == iss_rd1)
          - {{CNT_W{1'b0}}, dec[iss_rd1]};
  end

  assign dst_full0 = cnt_over(proj0);
  assign dst_full1 = cnt_over(proj1);

  // Sticky error: any counter clamp since the last reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err_q <= 1'b0;
    end else if ((|ovf) || (|unf)) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes expected output values tagged with the
// cycle they apply to; an independent negedge monitor pops and compares.
module tb_regfile_scoreboard;

  logic        clk, reset;
  logic        wb_en0, wb_en1, iss_en0, iss_en1;
  logic [4:0]  wb_rd0, wb_rd1, iss_rd0, iss_rd1, rs1_0, rs2_0, rs1_1, rs2_1;
  logic [31:0] wb_data0, wb_data1;
  logic [31:0] rdata1_0, rdata2_0, rdata1_1, rdata2_1;
  logic        busy1_0, busy2_0, busy1_1, busy2_1, dst_full0, dst_full1, sb_err;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .wb_en0(wb_en0), .wb_rd0(wb_rd0), .wb_data0(wb_data0),
    .wb_en1(wb_en1), .wb_rd1(wb_rd1), .wb_data1(wb_data1),
    .iss_en0(iss_en0), .iss_rd0(iss_rd0), .iss_en1(iss_en1), .iss_rd1(iss_rd1),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rs1_1(rs1_1), .rs2_1(rs2_1),
    .rdata1_0(rdata1_0), .rdata2_0(rdata2_0), .rdata1_1(rdata1_1), .rdata2_1(rdata2_1),
    .busy1_0(busy1_0), .busy2_0(busy2_0), .busy1_1(busy1_1), .busy2_1(busy2_1),
    .dst_full0(dst_full0), .dst_full1(dst_full1), .sb_err(sb_err)
  );

  localparam int R10 = 0, R20 = 1, R11 = 2, R21 = 3;
  localparam int B10 = 4, B20 = 5, B11 = 6, B21 = 7;
  localparam int DF0 = 8, DF1 = 9, ERR = 10;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      R10:     return rdata1_0;
      R20:     return rdata2_0;
      R11:     return rdata1_1;
      R21:     return rdata2_1;
      B10:     return {31'b0, busy1_0};
      B20:     return {31'b0, busy2_0};
      B11:     return {31'b0, busy1_1};
      B21:     return {31'b0, busy2_1};
      DF0:     return {31'b0, dst_full0};
      DF1:     return {31'b0, dst_full1};
      default: return {31'b0, sb_err};
    endcase
  endfunction

  // Monitor: compare every expectation that belongs to the current cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks = checks + 1;
      if (e.cyc < cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = actual(e.sel);
        if (act !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.name, cyc, act, e.exp);
        end
      end
    end
  end

  task automatic push_exp(string name, int sel, logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic clr();
    wb_en0 = 0; wb_rd0 = 0; wb_data0 = 0; wb_en1 = 0; wb_rd1 = 0; wb_data1 = 0;
    iss_en0 = 0; iss_rd0 = 0; iss_en1 = 0; iss_rd1 = 0;
    rs1_0 = 0; rs2_0 = 0; rs1_1 = 0; rs2_1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    tick();
    // Reset cycle: issue/write-back must be ignored.
    iss_en0 = 1; iss_rd0 = 10; wb_en0 = 1; wb_rd0 = 11; wb_data0 = 32'h55;
    tick();
    reset = 1'b0; clr();
    rs1_0 = 11; rs2_0 = 10; rs1_1 = 5;
    push_exp("rst_rdata", R10, 32'h0);
    push_exp("rst_rdata_b", R11, 32'h0);
    push_exp("rst_busy", B20, 32'h0);
    push_exp("rst_err", ERR, 32'h0);
    tick();

    // Write/read and x0 (x5 reserved first so the write-back is legal).
    clr(); iss_en0 = 1; iss_rd0 = 5; tick();
    clr(); wb_en0 = 1; wb_rd0 = 5; wb_data0 = 32'hDEADBEEF; rs1_0 = 5;
    push_exp("wr_bypass", R10, 32'hDEADBEEF);
    push_exp("wr_busy_retire", B10, 32'h0);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 0; wb_data0 = 32'h1234; rs1_0 = 5; rs2_0 = 0;
    push_exp("wr_array", R10, 32'hDEADBEEF);
    push_exp("x0_bypass", R20, 32'h0);
    tick();

    // Same-rd dual write, two reservations in one bundle.
    clr(); iss_en0 = 1; iss_rd0 = 7; iss_en1 = 1; iss_rd1 = 7;
    push_exp("dual_iss_full1", DF1, 32'h0);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 7; wb_data0 = 32'h11; wb_en1 = 1; wb_rd1 = 7; wb_data1 = 32'h22;
    rs1_1 = 7;
    push_exp("dual_bypass", R11, 32'h22);
    push_exp("dual_busy", B11, 32'h0);
    tick();
    clr(); rs2_1 = 7;
    push_exp("dual_array", R21, 32'h22);
    push_exp("dual_err", ERR, 32'h0);
    tick();

    // Scoreboard lifecycle on x3.
    clr(); iss_en0 = 1; iss_rd0 = 3; rs1_1 = 3;
    push_exp("lc_same_cycle", B11, 32'h0);
    tick();
    clr(); rs1_1 = 3;
    push_exp("lc_busy", B11, 32'h1);
    tick();
    clr(); wb_en1 = 1; wb_rd1 = 3; wb_data1 = 32'hAB; rs1_1 = 3;
    push_exp("lc_retire_busy", B11, 32'h0);
    push_exp("lc_retire_data", R11, 32'hAB);
    tick();
    clr(); rs1_1 = 3;
    push_exp("lc_idle", B11, 32'h0);
    tick();

    // Simultaneous issue and write-back on x4.
    clr(); iss_en0 = 1; iss_rd0 = 4; tick();
    clr(); iss_en1 = 1; iss_rd1 = 4; wb_en0 = 1; wb_rd0 = 4; wb_data0 = 32'h44; rs1_0 = 4;
    tick();
    clr(); rs1_0 = 4;
    push_exp("sim_busy", B10, 32'h1);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 4; wb_data0 = 32'h45; rs1_0 = 4;
    push_exp("sim_cnt_one", B10, 32'h0);
    tick();
    clr(); rs1_0 = 4;
    push_exp("sim_drained", B10, 32'h0);
    push_exp("sim_err", ERR, 32'h0);
    tick();

    // WAW depth and overflow on x9.
    for (int i = 0; i < 3; i++) begin
      clr(); iss_en0 = 1; iss_rd0 = 9;
      push_exp("waw_not_full", DF0, 32'h0);
      tick();
    end
    clr(); iss_rd0 = 9; iss_rd1 = 9; rs1_0 = 9;
    push_exp("waw_full0", DF0, 32'h1);
    push_exp("waw_full1", DF1, 32'h1);
    push_exp("waw_busy", B10, 32'h1);
    push_exp("waw_err_clear", ERR, 32'h0);
    tick();
    clr(); iss_en0 = 1; iss_rd0 = 9; tick();
    clr(); iss_rd0 = 9;
    push_exp("ovf_err", ERR, 32'h1);
    push_exp("ovf_cnt_held", DF0, 32'h1);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 9; wb_data0 = 32'h9; iss_rd0 = 9; rs1_0 = 9;
    push_exp("waw_wb_busy", B10, 32'h1);
    push_exp("waw_wb_full", DF0, 32'h0);
    tick();
    clr(); iss_rd0 = 9; rs1_0 = 9;
    push_exp("waw_cnt2_busy", B10, 32'h1);
    push_exp("waw_cnt2_full", DF0, 32'h0);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 9; wb_en1 = 1; wb_rd1 = 9; rs1_0 = 9;
    push_exp("waw_drain", B10, 32'h0);
    tick();

    // Reset mid-operation.
    clr(); iss_en0 = 1; iss_rd0 = 2; iss_en1 = 1; iss_rd1 = 6; tick();
    clr(); rs1_0 = 2; rs2_0 = 6;
    push_exp("pre_rst_busy2", B10, 32'h1);
    push_exp("pre_rst_busy6", B20, 32'h1);
    push_exp("pre_rst_err", ERR, 32'h1);
    tick();
    clr(); reset = 1'b1; iss_en0 = 1; iss_rd0 = 2; tick();
    reset = 1'b0; clr(); rs1_0 = 2; rs2_0 = 6; rs1_1 = 7;
    push_exp("mid_rst_busy2", B10, 32'h0);
    push_exp("mid_rst_busy6", B20, 32'h0);
    push_exp("mid_rst_err", ERR, 32'h0);
    push_exp("mid_rst_data", R11, 32'h0);
    tick();
    clr(); wb_en0 = 1; wb_rd0 = 2; wb_data0 = 32'hC0FFEE; rs2_1 = 2;
    push_exp("unf_bypass", R21, 32'hC0FFEE);
    push_exp("unf_err_pre", ERR, 32'h0);
    tick();
    clr(); rs2_1 = 2;
    push_exp("unf_err", ERR, 32'h1);
    push_exp("unf_data", R21, 32'hC0FFEE);
    push_exp("unf_busy", B21, 32'h0);
    tick();

    clr();
    tick();
    tick();
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      errors = errors + q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
